// File: rtl/sr_latch_bank.sv
// Bank of synchronous set/reset flag cells with selectable set/clear conflict resolution,
// an optional post-set minimum-hold window, edge pulses and conflict bookkeeping.
module sr_latch_bank #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned MODE        = 0,
  parameter int unsigned HOLD_CYCLES = 0,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [CHANNELS-1:0] set_i,
  input  logic [CHANNELS-1:0] clr_i,
  input  logic                conflict_ack_i,
  output logic [CHANNELS-1:0] q_o,
  output logic [CHANNELS-1:0] q_bar_o,
  output logic [CHANNELS-1:0] rise_o,
  output logic [CHANNELS-1:0] fall_o,
  output logic [CHANNELS-1:0] conflict_o,
  output logic [CNT_W-1:0]    conflict_cnt_o
);

  // A disabled timer still needs one bit of storage; it simply never loads non-zero.
  localparam int unsigned TW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [TW-1:0]    HoldLoad = TW'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CntMax   = '1;

  logic [CHANNELS-1:0] q_q, q_d;
  logic [CHANNELS-1:0] rise_q, rise_d;
  logic [CHANNELS-1:0] fall_q, fall_d;
  logic [CHANNELS-1:0] conf_q, conf_d;
  logic [TW-1:0]       tmr_q [CHANNELS];
  logic [TW-1:0]       tmr_d [CHANNELS];
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CHANNELS-1:0] eclr;
  logic [CHANNELS-1:0] both;

  always_comb begin
    both = set_i & clr_i;
    eclr = '0;
    q_d  = q_q;
    for (int i = 0; i < CHANNELS; i++) begin
      eclr[i] = clr_i[i] & (tmr_q[i] == '0);
      case ({set_i[i], eclr[i]})
        2'b10:   q_d[i] = 1'b1;
        2'b01:   q_d[i] = 1'b0;
        2'b11: begin
          case (MODE)
            0:       q_d[i] = 1'b0;
            1:       q_d[i] = 1'b1;
            3:       q_d[i] = ~q_q[i];
            default: q_d[i] = q_q[i];
          endcase
        end
        default: q_d[i] = q_q[i];
      endcase
    end

    for (int i = 0; i < CHANNELS; i++) begin
      if (q_d[i] && !q_q[i]) begin
        tmr_d[i] = HoldLoad;
      end else if (tmr_q[i] != '0) begin
        tmr_d[i] = tmr_q[i] - 1'b1;
      end else begin
        tmr_d[i] = tmr_q[i];
      end
    end

    rise_d = q_d & ~q_q;
    fall_d = ~q_d & q_q;
    // A fresh conflict overrides an acknowledge in the same cycle.
    conf_d = (conf_q & ~{CHANNELS{conflict_ack_i}}) | both;

    cnt_d = cnt_q;
    if ((|both) && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      q_q    <= '0;
      rise_q <= '0;
      fall_q <= '0;
      conf_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        tmr_q[i] <= '0;
      end
    end else begin
      q_q    <= q_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      conf_q <= conf_d;
      cnt_q  <= cnt_d;
      for (int i = 0; i < CHANNELS; i++) begin
        tmr_q[i] <= tmr_d[i];
      end
    end
  end

  assign q_o            = q_q;
  assign q_bar_o        = ~q_q;
  assign rise_o         = rise_q;
  assign fall_o         = fall_q;
  assign conflict_o     = conf_q;
  assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_sr_latch_bank.sv
// Drives eight sr_latch_bank variants (MODE 0-3, HOLD 0 with CNT_W 2, HOLD 3 with CNT_W 3) with
// shared stimulus; expected results are queued by the driver and popped by a monitor.
module tb_sr_latch_bank;

  localparam int NDUT = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       ack;
  logic [3:0] s_in;
  logic [3:0] c_in;

  logic [3:0] dq   [NDUT];
  logic [3:0] dqb  [NDUT];
  logic [3:0] dr   [NDUT];
  logic [3:0] df   [NDUT];
  logic [3:0] dc   [NDUT];
  logic [2:0] dcnt [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    if (g < 4) begin : g_c2
      logic [1:0] cnt2;
      sr_latch_bank #(
        .CHANNELS(4), .MODE(g % 4), .HOLD_CYCLES(0), .CNT_W(2)
      ) u_dut (
        .clk_i(clk), .reset_i(reset), .set_i(s_in), .clr_i(c_in), .conflict_ack_i(ack),
        .q_o(dq[g]), .q_bar_o(dqb[g]), .rise_o(dr[g]), .fall_o(df[g]),
        .conflict_o(dc[g]), .conflict_cnt_o(cnt2)
      );
      assign dcnt[g] = {1'b0, cnt2};
    end else begin : g_c3
      sr_latch_bank #(
        .CHANNELS(4), .MODE(g % 4), .HOLD_CYCLES(3), .CNT_W(3)
      ) u_dut (
        .clk_i(clk), .reset_i(reset), .set_i(s_in), .clr_i(c_in), .conflict_ack_i(ack),
        .q_o(dq[g]), .q_bar_o(dqb[g]), .rise_o(dr[g]), .fall_o(df[g]),
        .conflict_o(dc[g]), .conflict_cnt_o(dcnt[g])
      );
    end
  end

  typedef struct packed {
    logic [NDUT-1:0][3:0] q;
    logic [NDUT-1:0][3:0] rise;
    logic [NDUT-1:0][3:0] fall;
    logic [NDUT-1:0][3:0] conf;
    logic [NDUT-1:0][2:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference state: bit value, remaining protected edges, sticky flag, conflict count.
  bit mq   [NDUT][4];
  int mhold[NDUT][4];
  bit mconf[NDUT][4];
  int mcnt [NDUT];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] s, input logic [3:0] k, input logic a, input logic r);
    exp_t e;
    @(negedge clk);
    s_in  = s;
    c_in  = k;
    ack   = a;
    reset = r;
    e     = '0;
    for (int d = 0; d < NDUT; d++) begin
      int md;
      int hold;
      int cmax;
      md   = d % 4;
      hold = (d < 4) ? 0 : 3;
      cmax = (d < 4) ? 3 : 7;
      for (int c = 0; c < 4; c++) begin
        bit nq;
        bit eff_clr;
        if (r) begin
          mq[d][c]    = 0;
          mhold[d][c] = 0;
          mconf[d][c] = 0;
        end else begin
          eff_clr = k[c] && (mhold[d][c] == 0);
          if (s[c] && eff_clr) begin
            if (md == 0)      nq = 0;
            else if (md == 1) nq = 1;
            else if (md == 2) nq = mq[d][c];
            else              nq = !mq[d][c];
          end else if (s[c]) begin
            nq = 1;
          end else if (eff_clr) begin
            nq = 0;
          end else begin
            nq = mq[d][c];
          end
          e.rise[d][c] = nq && !mq[d][c];
          e.fall[d][c] = !nq && mq[d][c];
          if (nq && !mq[d][c]) mhold[d][c] = hold;
          else if (mhold[d][c] > 0) mhold[d][c] = mhold[d][c] - 1;
          mq[d][c]    = nq;
          mconf[d][c] = (mconf[d][c] && !a) || (s[c] && k[c]);
        end
        e.q[d][c]    = mq[d][c];
        e.conf[d][c] = mconf[d][c];
      end
      if (r) mcnt[d] = 0;
      else if (((s & k) != 4'h0) && (mcnt[d] < cmax)) mcnt[d] = mcnt[d] + 1;
      e.cnt[d] = 3'(mcnt[d]);
    end
    sb.push_back(e);
  endtask

  task automatic after_edge;
    @(posedge clk);
    #1;
  endtask

  // Monitor: the DUT presents a fresh result after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        for (int d = 0; d < NDUT; d++) begin
          chk($sformatf("q[%0d]", d), {4'h0, dq[d]}, {4'h0, e.q[d]});
          chk($sformatf("q_bar[%0d]", d), {4'h0, dqb[d]}, {4'h0, ~e.q[d]});
          chk($sformatf("rise[%0d]", d), {4'h0, dr[d]}, {4'h0, e.rise[d]});
          chk($sformatf("fall[%0d]", d), {4'h0, df[d]}, {4'h0, e.fall[d]});
          chk($sformatf("conflict[%0d]", d), {4'h0, dc[d]}, {4'h0, e.conf[d]});
          chk($sformatf("cnt[%0d]", d), {5'h0, dcnt[d]}, {5'h0, e.cnt[d]});
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    ack   = 1'b0;
    s_in  = 4'h0;
    c_in  = 4'h0;

    step(4'h0, 4'h0, 1'b0, 1'b1);
    step(4'h0, 4'h0, 1'b0, 1'b1);
    chk("reset q", {4'h0, dq[0]}, 8'h00);
    chk("reset q_bar", {4'h0, dqb[0]}, 8'h0F);

    // Basic set then clear.
    step(4'h1, 4'h0, 1'b0, 1'b0);
    after_edge;
    chk("basic set q", {4'h0, dq[0]}, 8'h01);
    chk("basic set q_bar", {4'h0, dqb[0]}, 8'h0E);
    chk("basic rise", {4'h0, dr[0]}, 8'h01);
    step(4'h0, 4'h1, 1'b0, 1'b0);
    after_edge;
    chk("basic clr q", {4'h0, dq[0]}, 8'h00);
    chk("basic fall", {4'h0, df[0]}, 8'h01);
    chk("basic clr masked hold3", {4'h0, dq[4]}, 8'h01);

    // Simultaneous set and clear on all channels.
    step(4'h0, 4'h0, 1'b0, 1'b1);
    step(4'hF, 4'hF, 1'b0, 1'b0);
    after_edge;
    chk("toggle e1 q", {4'h0, dq[3]}, 8'h0F);
    chk("toggle e1 rise", {4'h0, dr[3]}, 8'h0F);
    step(4'hF, 4'hF, 1'b0, 1'b0);
    after_edge;
    chk("toggle e2 q", {4'h0, dq[3]}, 8'h00);
    chk("toggle e2 fall", {4'h0, df[3]}, 8'h0F);
    step(4'hF, 4'hF, 1'b0, 1'b0);
    after_edge;
    chk("toggle e3 q", {4'h0, dq[3]}, 8'h0F);
    chk("mode0 q", {4'h0, dq[0]}, 8'h00);
    chk("mode1 q", {4'h0, dq[1]}, 8'h0F);
    chk("mode2 q", {4'h0, dq[2]}, 8'h00);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("both conflict[%0d]", d), {4'h0, dc[d]}, 8'h0F);
      chk($sformatf("both cnt[%0d]", d), {5'h0, dcnt[d]}, 8'h03);
    end

    // Conflict counter saturation and acknowledge.
    step(4'hF, 4'hF, 1'b0, 1'b0);
    step(4'hF, 4'hF, 1'b0, 1'b0);
    after_edge;
    chk("cnt saturated w2", {5'h0, dcnt[0]}, 8'h03);
    chk("cnt w3", {5'h0, dcnt[4]}, 8'h05);
    step(4'h0, 4'h0, 1'b1, 1'b0);
    after_edge;
    chk("ack clears", {4'h0, dc[0]}, 8'h00);
    chk("ack keeps cnt", {5'h0, dcnt[0]}, 8'h03);
    step(4'h4, 4'h4, 1'b1, 1'b0);
    after_edge;
    chk("ack vs new conflict", {4'h0, dc[0]}, 8'h04);

    // Hold window on the HOLD_CYCLES=3 bank.
    step(4'h0, 4'h0, 1'b0, 1'b1);
    step(4'h1, 4'h0, 1'b0, 1'b0);
    for (int n = 1; n <= 3; n++) begin
      step(4'h0, 4'h1, 1'b0, 1'b0);
      after_edge;
      chk($sformatf("hold edge %0d q", n), {4'h0, dq[4]}, 8'h01);
    end
    step(4'h0, 4'h1, 1'b0, 1'b0);
    after_edge;
    chk("hold edge 4 q", {4'h0, dq[4]}, 8'h00);
    chk("hold edge 4 fall", {4'h0, df[4]}, 8'h01);

    step(4'h0, 4'h0, 1'b0, 1'b1);
    step(4'h1, 4'h0, 1'b0, 1'b0);
    step(4'h1, 4'h1, 1'b0, 1'b0);
    after_edge;
    chk("masked set&clr mode0", {4'h0, dq[4]}, 8'h01);

    // Reset in the middle of a hold window.
    step(4'h0, 4'h0, 1'b0, 1'b1);
    step(4'hA, 4'h0, 1'b0, 1'b0);
    step(4'h0, 4'h0, 1'b0, 1'b0);
    step(4'h0, 4'h0, 1'b0, 1'b1);
    after_edge;
    chk("mid reset q", {4'h0, dq[4]}, 8'h00);
    chk("mid reset q_bar", {4'h0, dqb[4]}, 8'h0F);
    chk("mid reset fall", {4'h0, df[4]}, 8'h00);
    chk("mid reset cnt", {5'h0, dcnt[4]}, 8'h00);
    step(4'h1, 4'h0, 1'b0, 1'b0);
    for (int n = 1; n <= 3; n++) begin
      step(4'h0, 4'h1, 1'b0, 1'b0);
      after_edge;
      chk($sformatf("post reset hold %0d", n), {4'h0, dq[4]}, 8'h01);
    end
    step(4'h0, 4'h1, 1'b0, 1'b0);
    after_edge;
    chk("post reset clear", {4'h0, dq[4]}, 8'h00);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      step(4'($urandom), 4'($urandom), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 63) == 0));
    end

    @(posedge clk);
    #2;
    chk("scoreboard drained", 8'(sb.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
